// File: rtl/dc_val_file.sv
// DC value channel file: per-channel value/address/dirty state plus a single reload engine
// that writes back a dirty channel's value to its old address, then reads the new address.
module dc_val_file #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned NUM_DC     = 4,
  parameter int unsigned SEL_W      = $clog2(NUM_DC)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         write_en,
  input  logic [SEL_W-1:0]             write_sel,
  input  logic [WORD_WIDTH-1:0]        write_data,
  input  logic                         reload_req,
  input  logic [SEL_W-1:0]             reload_sel,
  input  logic [WORD_WIDTH-1:0]        reload_addr,
  output logic                         busy,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [WORD_WIDTH-1:0]        mem_addr,
  output logic [WORD_WIDTH-1:0]        mem_wdata,
  input  logic                         mem_ack,
  input  logic [WORD_WIDTH-1:0]        mem_rdata,
  output logic [NUM_DC*WORD_WIDTH-1:0] dc_vals,
  output logic [NUM_DC*WORD_WIDTH-1:0] dc_addrs,
  output logic [NUM_DC-1:0]            dc_dirty
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WB   = 2'd1;
  localparam logic [1:0] RD   = 2'd2;

  logic [1:0]            state;
  logic [WORD_WIDTH-1:0] ch_val  [NUM_DC];
  logic [WORD_WIDTH-1:0] ch_addr [NUM_DC];
  logic [NUM_DC-1:0]     ch_dirty;
  logic [SEL_W-1:0]      sel;
  logic [WORD_WIDTH-1:0] new_addr;
  logic [WORD_WIDTH-1:0] old_addr;
  logic [WORD_WIDTH-1:0] wb_data;
  // A core write to the reloading channel happened earlier in the current phase.
  logic                  ovr;
  logic                  hit;
  logic                  same_ch;

  assign hit     = write_en && (write_sel == sel);
  assign same_ch = write_en && (write_sel == reload_sel);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ch_dirty <= '0;
      sel      <= '0;
      new_addr <= '0;
      old_addr <= '0;
      wb_data  <= '0;
      ovr      <= 1'b0;
      for (int i = 0; i < int'(NUM_DC); i++) begin
        ch_val[i]  <= '0;
        ch_addr[i] <= '0;
      end
    end else begin
      if (write_en) begin
        ch_val[write_sel]   <= write_data;
        ch_dirty[write_sel] <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (reload_req) begin
            sel      <= reload_sel;
            new_addr <= reload_addr;
            old_addr <= ch_addr[reload_sel];
            wb_data  <= same_ch ? write_data : ch_val[reload_sel];
            ovr      <= 1'b0;
            state    <= (same_ch || ch_dirty[reload_sel]) ? WB : RD;
          end
        end
        WB: begin
          if (hit) ovr <= 1'b1;
          if (mem_ack) begin
            // A write during write-back means the channel is dirty again.
            if (!(ovr || hit)) ch_dirty[sel] <= 1'b0;
            ovr   <= 1'b0;
            state <= RD;
          end
        end
        RD: begin
          if (hit) ovr <= 1'b1;
          if (mem_ack) begin
            ch_addr[sel] <= new_addr;
            // Core data written during the read wins over the fetched value.
            if (!(ovr || hit)) begin
              ch_val[sel]   <= mem_rdata;
              ch_dirty[sel] <= 1'b0;
            end
            ovr   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    mem_req   = (state == WB) || (state == RD);
    mem_we    = (state == WB);
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == WB) begin
      mem_addr  = old_addr;
      mem_wdata = wb_data;
    end else if (state == RD) begin
      mem_addr  = new_addr;
    end
  end

  for (genvar g = 0; g < int'(NUM_DC); g++) begin : g_pack
    assign dc_vals[g*WORD_WIDTH +: WORD_WIDTH]  = ch_val[g];
    assign dc_addrs[g*WORD_WIDTH +: WORD_WIDTH] = ch_addr[g];
  end
  assign dc_dirty = ch_dirty;

endmodule
